// File: rtl/axi_slv_rd_pkg.sv
// ============================================================================
// Module  : axi_slv_rd_pkg
// Brief   : Shared AXI encodings, AR request record and next-beat address helper.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

`ifndef AXI_DEFINES_SV
`define AXI_DEFINES_SV
`define AXI_ID_WIDTH     4
`define AXI_ADDR_WIDTH   32
`define AXI_LEN_WIDTH    8
`define AXI_SIZE_WIDTH   3
`define AXI_BURST_WIDTH  2
`define AXI_USER_WIDTH   4
`define AXI_DATA_WIDTH   32
`define AXI_RESP_WIDTH   2
`define AXI_BURST_FIXED  2'b00
`define AXI_BURST_INCR   2'b01
`define AXI_BURST_WRAP   2'b10
`define AXI_SIZE_1B      3'b000
`define AXI_SIZE_2B      3'b001
`define AXI_SIZE_4B      3'b010
`define AXI_SIZE_8B      3'b011
`define AXI_RESP_OKAY    2'b00
`define AXI_RESP_EXOKAY  2'b01
`define AXI_RESP_SLVERR  2'b10
`define AXI_RESP_DECERR  2'b11
`endif

package axi_slv_rd_pkg;

    localparam int C_AW = `AXI_ADDR_WIDTH;
    localparam logic [`AXI_SIZE_WIDTH-1:0] C_MAX_SIZE =
        `AXI_SIZE_WIDTH'($clog2(`AXI_DATA_WIDTH/8));

    typedef struct packed {
        logic [`AXI_ID_WIDTH-1:0]    id;
        logic [`AXI_ADDR_WIDTH-1:0]  addr;
        logic [`AXI_LEN_WIDTH-1:0]   len;
        logic [`AXI_SIZE_WIDTH-1:0]  size;
        logic [`AXI_BURST_WIDTH-1:0] burst;
        logic [`AXI_USER_WIDTH-1:0]  user;
    } ar_req_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rd_state_t;

    // Address of the beat following 'cur' within a burst.
    function automatic logic [C_AW-1:0] axi_next_addr(
        input logic [`AXI_BURST_WIDTH-1:0] burst,
        input logic [`AXI_SIZE_WIDTH-1:0]  size,
        input logic [`AXI_LEN_WIDTH-1:0]   len,
        input logic [C_AW-1:0]             cur
    );
        logic [C_AW-1:0] w_bytes;
        logic [C_AW-1:0] w_wrap;
        w_bytes = C_AW'(1) << size;
        w_wrap  = w_bytes * (C_AW'(len) + C_AW'(1));
        case (burst)
            `AXI_BURST_INCR: return (cur & ~(w_bytes - C_AW'(1))) + w_bytes;
            `AXI_BURST_WRAP: return (cur & ~(w_wrap - C_AW'(1))) |
                                    ((cur + w_bytes) & (w_wrap - C_AW'(1)));
            default:         return cur;
        endcase
    endfunction

    function automatic logic axi_rd_slverr(
        input logic [`AXI_BURST_WIDTH-1:0] burst,
        input logic [`AXI_SIZE_WIDTH-1:0]  size,
        input logic [`AXI_LEN_WIDTH-1:0]   len
    );
        logic w_bad_wrap;
        w_bad_wrap = (burst == `AXI_BURST_WRAP) &&
                     !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
        return (size > C_MAX_SIZE) || w_bad_wrap;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_sync_fifo.sv
// ============================================================================
// Module  : axi_sync_fifo
// Brief   : Show-ahead synchronous in-order queue with occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int C_PW  = $clog2(DEPTH),
    localparam int C_CW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [C_CW-1:0]  o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_PW-1:0]  r_wr_ptr;
    logic [C_PW-1:0]  r_rd_ptr;
    logic [C_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == C_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + C_PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + C_PW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + C_CW'(1);
                2'b01:   r_count <= r_count - C_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/axi_slv_rd.sv
// ============================================================================
// Module  : axi_slv_rd
// Brief   : AXI read slave returning address-derived data, in-order AR queue.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_slv_rd
    import axi_slv_rd_pkg::*;
#(
    parameter int                         OST_DEPTH  = 4,
    parameter logic [`AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = 'h1000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [`AXI_ID_WIDTH-1:0]    axi_slv_arid,
    input  logic [`AXI_ADDR_WIDTH-1:0]  axi_slv_araddr,
    input  logic [`AXI_LEN_WIDTH-1:0]   axi_slv_arlen,
    input  logic [`AXI_SIZE_WIDTH-1:0]  axi_slv_arsize,
    input  logic [`AXI_BURST_WIDTH-1:0] axi_slv_arburst,
    input  logic [`AXI_USER_WIDTH-1:0]  axi_slv_aruser,
    input  logic                        axi_slv_arvalid,
    output logic                        axi_slv_arready,
    output logic [`AXI_ID_WIDTH-1:0]    axi_slv_rid,
    output logic [`AXI_DATA_WIDTH-1:0]  axi_slv_rdata,
    output logic [`AXI_RESP_WIDTH-1:0]  axi_slv_rresp,
    output logic [`AXI_USER_WIDTH-1:0]  axi_slv_ruser,
    output logic                        axi_slv_rlast,
    output logic                        axi_slv_rvalid,
    input  logic                        axi_slv_rready
);

    localparam int C_OW = $clog2(OST_DEPTH + 1);

    ar_req_t                       w_ar_req;
    ar_req_t                       w_head;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_full;
    logic                          w_empty;
    logic [C_OW-1:0]               w_fifo_count;
    logic [C_OW-1:0]               w_occ;

    rd_state_t                     r_state;
    rd_state_t                     w_state_nxt;
    ar_req_t                       r_cur;
    ar_req_t                       w_cur_nxt;
    logic [`AXI_LEN_WIDTH-1:0]     r_beat;
    logic [`AXI_LEN_WIDTH-1:0]     w_beat_nxt;
    logic                          w_hs;
    logic                          w_load;
    logic                          w_slverr;
    logic                          w_decerr;

    logic                          r_rvalid,  w_rvalid_nxt;
    logic                          r_rlast,   w_rlast_nxt;
    logic [`AXI_DATA_WIDTH-1:0]    r_rdata,   w_rdata_nxt;
    logic [`AXI_RESP_WIDTH-1:0]    r_rresp,   w_rresp_nxt;

    assign w_ar_req = '{id:    axi_slv_arid,
                        addr:  axi_slv_araddr,
                        len:   axi_slv_arlen,
                        size:  axi_slv_arsize,
                        burst: axi_slv_arburst,
                        user:  axi_slv_aruser};

    // The active burst lives in r_cur, so it counts toward occupancy until its last beat.
    assign w_occ           = w_fifo_count + C_OW'(r_state == ST_BURST);
    assign axi_slv_arready = !w_full && (w_occ < C_OW'(OST_DEPTH));
    assign w_push          = axi_slv_arvalid && axi_slv_arready;

    axi_sync_fifo #(
        .WIDTH ($bits(ar_req_t)),
        .DEPTH (OST_DEPTH)
    ) u_ar_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_ar_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_nxt    = r_cur;
        w_beat_nxt   = r_beat;
        w_rvalid_nxt = r_rvalid;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        w_hs         = r_rvalid && axi_slv_rready;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_load = 1'b1;
            end
            ST_BURST: begin
                if (w_hs) begin
                    if (r_rlast) begin
                        if (!w_empty) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt  = ST_IDLE;
                            w_rvalid_nxt = 1'b0;
                        end
                    end else begin
                        w_beat_nxt     = r_beat + `AXI_LEN_WIDTH'(1);
                        w_cur_nxt.addr = axi_next_addr(r_cur.burst, r_cur.size,
                                                       r_cur.len, r_cur.addr);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_load) begin
            w_pop        = 1'b1;
            w_cur_nxt    = w_head;
            w_beat_nxt   = '0;
            w_state_nxt  = ST_BURST;
            w_rvalid_nxt = 1'b1;
        end

        // Payload of the beat that will be presented after this edge.
        w_slverr    = axi_rd_slverr(w_cur_nxt.burst, w_cur_nxt.size, w_cur_nxt.len);
        w_decerr    = (w_cur_nxt.addr >= ADDR_LIMIT);
        w_rresp_nxt = w_slverr ? `AXI_RESP_SLVERR :
                      w_decerr ? `AXI_RESP_DECERR : `AXI_RESP_OKAY;
        w_rdata_nxt = (w_slverr || w_decerr) ? '0 : `AXI_DATA_WIDTH'(w_cur_nxt.addr);
        w_rlast_nxt = w_rvalid_nxt && (w_beat_nxt == w_cur_nxt.len);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cur    <= '0;
            r_beat   <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= `AXI_RESP_OKAY;
        end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_beat   <= w_beat_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rlast  <= w_rlast_nxt;
            r_rdata  <= w_rdata_nxt;
            r_rresp  <= w_rresp_nxt;
        end
    end

    assign axi_slv_rvalid = r_rvalid;
    assign axi_slv_rlast  = r_rlast;
    assign axi_slv_rdata  = r_rdata;
    assign axi_slv_rresp  = r_rresp;
    assign axi_slv_rid    = r_cur.id;
    assign axi_slv_ruser  = r_cur.user;

endmodule

`default_nettype wire

// File: doc/axi_slv_rd.md
# axi_slv_rd

AXI read-channel slave responder: the counterpart to the codebase's AXI read master. It accepts AR requests into an in-order outstanding queue and generates FIXED/INCR/WRAP beat addresses. It returns R beats carrying deterministic, address-derived data so benches can check every beat without a backing memory model. It sits on the slave side of the AXI interconnect or directly opposite a read master in block-level simulation.

## Interface
Parameters:
- OST_DEPTH, 4: max accepted-but-not-completed bursts, including the burst currently returning data; power of two, ≥2.
- ADDR_LIMIT, 'h1000: beat byte addresses ≥ ADDR_LIMIT return DECERR.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- axi_slv_arid / araddr / arlen / arsize / arburst / aruser  in  `AXI_ID_WIDTH / `AXI_ADDR_WIDTH / `AXI_LEN_WIDTH / `AXI_SIZE_WIDTH / `AXI_BURST_WIDTH / `AXI_USER_WIDTH  AR payload.
- axi_slv_arvalid  in  1  AR valid.
- axi_slv_arready  out  1  AR ready.
- axi_slv_rid / rdata / rresp / ruser  out  `AXI_ID_WIDTH / `AXI_DATA_WIDTH / `AXI_RESP_WIDTH / `AXI_USER_WIDTH  R payload.
- axi_slv_rlast  out  1  last beat of burst.
- axi_slv_rvalid  out  1  R valid.
- axi_slv_rready  in  1  R ready.

## Operation
- AR handshake (arvalid & arready) pushes {id, addr, len, size, burst, user} into the in-order queue. arready = (occupancy < OST_DEPTH), combinational from registered occupancy only; no dependence on arvalid.
- Queue entry is freed on the handshake of its last R beat. Responses are strictly in acceptance order regardless of ID.
- R FSM: IDLE → BURST when the queue is non-empty; loads head entry and sets beat counter 0. In BURST, each R handshake advances the beat; on the last-beat handshake, go to the next entry if present (no bubble), else IDLE.
- Beat 0 address = araddr. Bytes per beat B = 1 << arsize.
- FIXED: every beat uses araddr.
- INCR: beat n = (araddr & ~(B-1)) + n·B, for n ≥ 1; modulo 2^`AXI_ADDR_WIDTH; no 4 KB check.
- WRAP: container W = B·(arlen+1); next = (cur & ~(W-1)) | ((cur + B) & (W-1)).
- rdata = current beat address zero-extended to `AXI_DATA_WIDTH; rid = arid; ruser = aruser.
- rresp per beat, first match wins:
  - SLVERR: B > `AXI_DATA_WIDTH/8, or WRAP with arlen ∉ {1,3,7,15}.
  - DECERR: beat address ≥ ADDR_LIMIT.
  - Otherwise OKAY.
- rdata is forced to 0 on any error beat. Errored bursts still return exactly arlen+1 beats.
- rlast = (beat counter == arlen).

## Timing
- Reset values: arready 1 (queue empty), rvalid 0, rlast 0, rid 0, rdata 0, rresp OKAY, ruser 0. FSM → IDLE, queue cleared, beat counter 0.
- Reset asserted mid-burst: the burst is abandoned immediately; no further beats after release.
- Latency: AR handshake at edge k → rvalid high after edge k+1 when the R path is idle.
- R outputs are registered. While rvalid & !rready, every R output holds stable.
- Throughput: one beat per cycle while rready is high, including across burst boundaries.
- Full queue: arready low. A same-cycle last-beat pop does not raise arready until the next cycle; no bypass.
- Simultaneous push and pop when not full: occupancy unchanged, both take effect.
- Occupancy counter width: $clog2(OST_DEPTH+1).

## Structure
- Burst/size/resp encodings come from the existing shared AXI define package (`AXI_BURST_*, `AXI_SIZE_*, `AXI_RESP_*).
- Add a shared next-beat-address function (burst, size, len, cur) to that package so the master-side checker reuses it.
- One sub-module: axi_sync_fifo, a parameterised width/depth in-order queue with push/pop/full/empty/count. Instantiated for the AR queue.

## Test plan
- INCR araddr 0x10, arlen 3, size 4 B, arid 2, rready=1 → rdata 0x10, 0x14, 0x18, 0x1C, all OKAY. rid 2 on every beat; rlast only on beat 4; first rvalid one cycle after AR handshake.
- WRAP araddr 0x24, arlen 3, size 4 B → rdata 0x24, 0x28, 0x2C, 0x20.
- FIXED araddr 0x30, arlen 3 → four beats of 0x30.
- rready low for 3 cycles mid-burst → rdata/rlast/rid frozen; no beat lost or duplicated.
- OST_DEPTH=4, rready=0, five back-to-back ARs → arready low after the 4th. The 5th is accepted only in the cycle after the first burst's last-beat handshake. Bursts return in order with no bubble.
- Error bursts:
  - araddr 0xFF8, INCR, arlen 3, size 4 B → beats 0xFF8/0xFFC OKAY, then 2 DECERR beats with rdata 0.
  - arsize beyond data width → 4 SLVERR beats.
  - rst_n pulsed mid-burst → all outputs return to reset values.
